p2s_tx: RTL and testbench
=========================

Name: p2s_tx

Overview:
- Parallel-to-serial transmitter for the angle word consumed by the datapath's serial input: the far end of the `e`/`en` link.
- Accepts WIDTH-bit words on a valid/ready interface and buffers them in a DEPTH-entry FIFO.
- Serializes each word MSB-first on `dext`, one bit per clock, with `en` high for exactly the WIDTH bit cycles of each word.
- Sits on the stimulus/source side and drives `e`/`en` of the top-level datapath.

Parameters:
- WIDTH, 10, bits per serialized word.
- DEPTH, 4, FIFO entries; power of 2, ≥2.
- GAP, 2, idle cycles (`en`=0) inserted after each word; ≥0.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- din_valid  in  1  input word valid.
- din  in  WIDTH  input word.
- din_ready  out  1  FIFO can accept; write occurs on `din_valid && din_ready` at the clock edge.
- dext  out  1  serial data, MSB first; 0 whenever `en`=0.
- en  out  1  high during each of the WIDTH bit cycles of a word.
- frame  out  1  high only on the first (MSB) bit cycle of each word.
- busy  out  1  high when the FSM is not in IDLE or the FIFO is non-empty.
- count  out  clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- **Reset** (`rst`=1 at an edge):
  - FIFO is flushed: pointers 0, `count`=0.
  - FSM goes to IDLE; shift register and bit counter cleared.
  - `en`=0, `dext`=0, `frame`=0, `busy`=0.
  - While `rst`=1, `din_ready`=0 and writes are ignored.
  - Reset mid-word abandons the word: no further bits are sent and `en` is 0 from the cycle after the reset edge.
- **din_ready** = (`count` != DEPTH) && !rst, combinational from registered `count`.
  - No bypass: when full, a write is refused even if a pop happens on the same edge.
- **FIFO**: `count` updates +1 on write only, −1 on pop only, unchanged on simultaneous write and pop. Pointers wrap modulo DEPTH.
- **FSM states**: IDLE, SHIFT, GAP. `en`, `dext` and `frame` are registered outputs.
- **IDLE**: at an edge with `count`>0, pop the head into the shift register and go to SHIFT with bitcnt = WIDTH−1. After that edge, `en`=1, `frame`=1, `dext`=word[WIDTH−1].
- **SHIFT**: each edge shifts left by one and decrements bitcnt, so `dext` presents bits WIDTH−1 down to 0 on successive cycles and `frame`=0 after the first cycle. At the edge ending bit 0:
  - If GAP>0: go to GAP with gapcnt = GAP−1; `en`=0, `dext`=0.
  - If GAP=0 and FIFO non-empty: pop and load the next word directly (`en` stays 1, `frame`=1).
  - Otherwise: go to IDLE.
- **GAP**: `en`=0. At the edge ending the last gap cycle, if the FIFO is non-empty, pop and load directly into SHIFT; otherwise go to IDLE.
- **Timing**:
  - Back-to-back words have a period of exactly WIDTH+GAP cycles.
  - First-word latency: write at edge k into an empty, idle block → first bit valid in the cycle after edge k+1.
- **Simultaneous events**: a write into an empty FIFO while the FSM is at a load edge is not visible to that load; it is popped at the next load opportunity.
- **busy** is combinational: (state != IDLE) || (`count` != 0).

Test Plan:
1. **Single word**: reset, then one write of 10'h2AD → `en` high for exactly 10 cycles starting 2 cycles after the write edge; `dext` = 1,0,1,0,1,0,1,1,0,1; `frame` high on the first cycle only; `busy` falls after GAP=2 idle cycles.
2. **Burst/backpressure**: DEPTH=4, GAP=2, hold `din_valid` with words 0x001..0x006 → `din_ready` drops when `count`=4; all six words emerge in order with `frame` pulses exactly 12 cycles apart; no word lost or duplicated.
3. **GAP=0 streaming**: push 0x3FF then 0x000 → `en` continuously high for 20 cycles; `dext` ten 1s then ten 0s; `frame` pulses at cycles 0 and 10.
4. **Reset mid-word**: assert `rst` for 1 cycle during bit 5 of 0x155 with 2 words queued → `en`=0 from the next cycle, `count`=0, no residual bits; a subsequent write of 0x0F0 serializes correctly.
5. **Full with pop**: fill the FIFO to 4 and present a write on the same edge as a pop → write refused (`din_ready`=0), `count` goes 4→3.
6. **Random scoreboard**: 200 random words with random `din_valid` gaps, GAP ∈ {0,1,3} → a bench deserializer sampling `dext` on `en`=1 (MSB first, aligned to `frame`) reproduces every word in order; `dext`=0 whenever `en`=0.

Source files
------------

// File: rtl/p2s_tx.sv
// p2s_tx: parallel-to-serial transmitter driving the e/en serial link.
// Words are queued in a small FIFO and shifted out MSB-first, one bit per clock.
// Each word is followed by GAP idle cycles.
module p2s_tx #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned GAP   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     din_valid,
    input  logic [WIDTH-1:0]         din,
    output logic                     din_ready,
    output logic                     dext,
    output logic                     en,
    output logic                     frame,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-2:0] rest;
    logic [BW-1:0]    bitcnt;
    logic [GW-1:0]    gapcnt;
    logic [WIDTH-1:0] head;
    logic             have_word;
    logic             wr;
    logic             pop;

    assign head      = mem[rd_ptr];
    assign have_word = (count != '0);
    assign din_ready = (count != CW'(DEPTH)) && !rst;
    assign wr        = din_valid && din_ready;
    assign busy      = (state != ST_IDLE) || have_word;

    // Load opportunities: idle, last bit with no gap, or last gap cycle.
    always_comb begin
        pop = 1'b0;
        case (state)
            ST_IDLE:  pop = have_word;
            ST_SHIFT: pop = have_word && (bitcnt == '0) && (GAP == 0);
            ST_GAP:   pop = have_word && (gapcnt == '0);
            default:  pop = 1'b0;
        endcase
    end

    // FIFO storage; writes are already blocked during reset via din_ready.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr] <= din;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (wr && !pop) begin
                count <= count + CW'(1);
            end else if (!wr && pop) begin
                count <= count - CW'(1);
            end
        end
    end

    // Serializer FSM with registered en/dext/frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            rest   <= '0;
            bitcnt <= '0;
            gapcnt <= '0;
            en     <= 1'b0;
            dext   <= 1'b0;
            frame  <= 1'b0;
        end else begin
            frame <= 1'b0;
            if (pop) begin
                state  <= ST_SHIFT;
                rest   <= head[WIDTH-2:0];
                bitcnt <= BW'(WIDTH - 1);
                en     <= 1'b1;
                dext   <= head[WIDTH-1];
                frame  <= 1'b1;
            end else begin
                case (state)
                    ST_SHIFT: begin
                        if (bitcnt != '0) begin
                            dext   <= rest[WIDTH-2];
                            rest   <= rest << 1;
                            bitcnt <= bitcnt - BW'(1);
                        end else begin
                            en   <= 1'b0;
                            dext <= 1'b0;
                            if (GAP > 0) begin
                                state  <= ST_GAP;
                                gapcnt <= GW'((GAP > 0) ? GAP - 1 : 0);
                            end else begin
                                state <= ST_IDLE;
                            end
                        end
                    end
                    ST_GAP: begin
                        if (gapcnt != '0) begin
                            gapcnt <= gapcnt - GW'(1);
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_p2s_tx.sv
// Bench for p2s_tx: four instances (GAP = 2, 0, 1, 3) share clock and reset.
// Accepted words are queued per instance; a monitor deserializes dext and
// compares each completed word, plus occupancy and ready, against the model.
module tb_p2s_tx;

    localparam int NI = 4;
    localparam int W  = 10;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NI-1:0]   din_valid = '0;
    logic [W-1:0]    din [NI];
    logic [NI-1:0]   din_ready;
    logic [NI-1:0]   dext;
    logic [NI-1:0]   en;
    logic [NI-1:0]   frame;
    logic [NI-1:0]   busy;
    logic [2:0]      count [NI];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit drain_go = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (busy != '0 && t < 500);
        check("idle_timeout", int'(busy), 0);
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int GV = (g == 0) ? 2 : (g == 1) ? 0 : (g == 2) ? 1 : 3;

        logic [W-1:0] exp_q [$];
        int           pend = 0;
        int           nbits = 0;
        int           prev_fc = 0;
        bit           chain = 1'b0;
        bit           acc_s = 1'b0;
        bit           rst_s = 1'b0;
        logic [W-1:0] sh = '0;
        logic [W-1:0] din_s = '0;

        p2s_tx #(.WIDTH(W), .DEPTH(4), .GAP(GV)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .din_valid (din_valid[g]),
            .din       (din[g]),
            .din_ready (din_ready[g]),
            .dext      (dext[g]),
            .en        (en[g]),
            .frame     (frame[g]),
            .busy      (busy[g]),
            .count     (count[g])
        );

        // Monitor: deserialize at negedge, update the scoreboard at posedge.
        initial begin
            forever begin
                @(negedge clk);
                if (en[g]) begin
                    check($sformatf("g%0d_frame", g), int'(frame[g]), int'(nbits == 0));
                    if (frame[g]) begin
                        if (chain) check($sformatf("g%0d_period", g), cyc - prev_fc, W + GV);
                        prev_fc = cyc;
                        chain = 1'b0;
                        if (pend == 0) check($sformatf("g%0d_pop_underflow", g), pend, 1);
                        else pend--;
                    end
                    sh = {sh[W-2:0], dext[g]};
                    nbits++;
                    if (nbits == W) begin
                        if (exp_q.size() == 0) check($sformatf("g%0d_extra_word", g), 0, 1);
                        else check($sformatf("g%0d_word", g), int'(sh), int'(exp_q.pop_front()));
                        nbits = 0;
                        chain = (pend > 0);
                    end
                end else begin
                    check($sformatf("g%0d_dext_idle", g), int'(dext[g]), 0);
                    check($sformatf("g%0d_frame_idle", g), int'(frame[g]), 0);
                    if (nbits != 0) check($sformatf("g%0d_en_drop", g), nbits, 0);
                    nbits = 0;
                end
                check($sformatf("g%0d_count", g), int'(count[g]), pend);
                check($sformatf("g%0d_ready", g), int'(din_ready[g]), int'(pend != 4 && !rst));
                acc_s = din_valid[g] && din_ready[g];
                din_s = din[g];
                rst_s = rst;
                @(posedge clk);
                if (rst_s) begin
                    exp_q.delete();
                    pend  = 0;
                    nbits = 0;
                    chain = 1'b0;
                end else if (acc_s) begin
                    exp_q.push_back(din_s);
                    pend++;
                end
            end
        end

        // End-of-run: every accepted word must have been delivered.
        initial begin
            wait (drain_go);
            check($sformatf("g%0d_undelivered", g), exp_q.size(), 0);
            check($sformatf("g%0d_partial_bits", g), nbits, 0);
        end
    end

    logic [W-1:0] w1   = 10'h2AD;
    logic [W-1:0] w155 = 10'h155;
    bit           saw_low;
    bit           acc;
    int           sent [NI];
    bit           accd [NI];
    bit           all_done;

    initial begin
        for (int g = 0; g < NI; g++) din[g] = '0;

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            check("rst_en", int'(en[g]), 0);
            check("rst_dext", int'(dext[g]), 0);
            check("rst_frame", int'(frame[g]), 0);
            check("rst_busy", int'(busy[g]), 0);
            check("rst_count", int'(count[g]), 0);
            check("rst_ready", int'(din_ready[g]), 0);
        end
        tick();
        rst = 1'b0;
        tick();

        // Single word 0x2AD, GAP=2: latency, bit order, frame, busy tail
        din[0] = w1;
        din_valid[0] = 1'b1;
        tick();
        din_valid[0] = 1'b0;
        for (int i = 0; i <= 13; i++) begin
            @(negedge clk);
            check("t1_en", int'(en[0]), int'(i >= 1 && i <= 10));
            check("t1_frame", int'(frame[0]), int'(i == 1));
            check("t1_dext", int'(dext[0]), (i >= 1 && i <= 10) ? int'(w1[10 - i]) : 0);
            check("t1_busy", int'(busy[0]), int'(i <= 12));
        end

        // Burst with backpressure: six words held on din_valid
        saw_low = 1'b0;
        for (int w = 1; w <= 6; w++) begin
            din[0] = W'(w);
            din_valid[0] = 1'b1;
            acc = 1'b0;
            for (int t = 0; t < 100 && !acc; t++) begin
                @(negedge clk);
                acc = din_ready[0];
                if (!acc) saw_low = 1'b1;
                tick();
            end
            check("t2_accept_timeout", int'(acc), 1);
        end
        din_valid[0] = 1'b0;
        check("t2_ready_dropped", int'(saw_low), 1);
        wait_idle();

        // GAP=0 streaming: 0x3FF then 0x000 gives 20 contiguous en cycles
        tick();
        din[1] = 10'h3FF;
        din_valid[1] = 1'b1;
        tick();
        din[1] = 10'h000;
        tick();
        din_valid[1] = 1'b0;
        for (int i = 1; i <= 21; i++) begin
            @(negedge clk);
            check("t3_en", int'(en[1]), int'(i <= 20));
            check("t3_frame", int'(frame[1]), int'(i == 1 || i == 11));
            check("t3_dext", int'(dext[1]), int'(i <= 10));
        end
        wait_idle();

        // Full FIFO: write refused on the pop edge, count 4 -> 3
        tick();
        for (int j = 0; j < 5; j++) begin
            din[0] = W'(10'h100 + j);
            din_valid[0] = 1'b1;
            tick();
        end
        din[0] = 10'h1FF;
        for (int j = 4; j <= 12; j++) begin
            @(negedge clk);
            check("t5_count_full", int'(count[0]), 4);
            check("t5_ready_full", int'(din_ready[0]), 0);
            tick();
        end
        @(negedge clk);
        check("t5_count_after_pop", int'(count[0]), 3);
        check("t5_ready_after_pop", int'(din_ready[0]), 1);
        check("t5_frame_on_pop", int'(frame[0]), 1);
        tick();
        din_valid[0] = 1'b0;
        @(negedge clk);
        check("t5_count_refill", int'(count[0]), 4);
        wait_idle();

        // Reset during bit 5 of 0x155 with two words queued
        tick();
        din[0] = w155;
        din_valid[0] = 1'b1;
        tick();
        din[0] = 10'h0AA;
        tick();
        din[0] = 10'h333;
        tick();
        din_valid[0] = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("t4_en_before", int'(en[0]), 1);
        check("t4_bit5", int'(dext[0]), int'(w155[5]));
        check("t4_count_before", int'(count[0]), 2);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("t4_en_after", int'(en[0]), 0);
            check("t4_dext_after", int'(dext[0]), 0);
            check("t4_count_after", int'(count[0]), 0);
            check("t4_busy_after", int'(busy[0]), 0);
        end
        tick();
        din[0] = 10'h0F0;
        din_valid[0] = 1'b1;
        tick();
        din_valid[0] = 1'b0;
        wait_idle();

        // Random traffic on all instances
        tick();
        for (int g = 0; g < NI; g++) begin
            sent[g] = 0;
            accd[g] = 1'b0;
        end
        for (int t = 0; t < 20000; t++) begin
            all_done = 1'b1;
            for (int g = 0; g < NI; g++) if (sent[g] < 200) all_done = 1'b0;
            if (all_done) break;
            @(negedge clk);
            for (int g = 0; g < NI; g++) accd[g] = din_valid[g] && din_ready[g];
            tick();
            for (int g = 0; g < NI; g++) begin
                if (accd[g]) begin
                    sent[g]++;
                    din_valid[g] = 1'b0;
                end
                if (!din_valid[g] && sent[g] < 200 && $urandom_range(0, 3) != 0) begin
                    din[g] = W'($urandom);
                    din_valid[g] = 1'b1;
                end
            end
        end
        din_valid = '0;
        for (int g = 0; g < NI; g++) check("t6_sent", sent[g], 200);
        wait_idle();

        drain_go = 1'b1;
        @(negedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
